// File: rtl/burst_addr_seq_if.sv
// Memory request port of the burst address sequencer.
// The sequencer is the master: it presents req/addr/last, the memory returns ack.
interface burst_addr_seq_if #(
  parameter int ADDR_W = 16
) ();
  logic              mem_req;
  logic              mem_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_last;

  modport master (output mem_req, output mem_addr, output mem_last, input mem_ack);
  modport slave  (input mem_req, input mem_addr, input mem_last, output mem_ack);
endinterface

// File: rtl/burst_addr_seq.sv
// Burst address sequencer: turns one start command into a stream of memory
// requests. The external saturating up-counter steps through the beats and is
// driven through the cnt_* strobes. The request address is base_q plus the
// counter value, which is read back every cycle.
module burst_addr_seq #(
  parameter int SIZECOUNT = 12,
  parameter int ADDR_W    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  // command
  input  logic                 start,
  input  logic [SIZECOUNT-1:0] start_offset,
  input  logic [SIZECOUNT-1:0] start_len,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic                 abort,
  // status
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  // memory request port
  burst_addr_seq_if.master     mem,
  // counter control
  output logic                 cnt_clear,
  output logic                 cnt_load,
  output logic [SIZECOUNT-1:0] cnt_load_value,
  output logic [SIZECOUNT-1:0] cnt_max,
  output logic                 cnt_go,
  input  logic [SIZECOUNT-1:0] cnt_count
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ISSUE, S_DONE} state_t;

  // Burst context captured on an accepted start and held until the next one.
  typedef struct packed {
    logic [ADDR_W-1:0]    base;
    logic [SIZECOUNT-1:0] max;
    logic [SIZECOUNT-1:0] ldv;
  } ctx_t;

  state_t state_q, state_d;
  ctx_t   ctx_q;
  logic   err_q;   // start rejected last cycle
  logic   abrt_q;  // burst aborted last cycle, counter must be cleared
  logic   zl_q;    // current DONE came from a zero-length start

  logic [SIZECOUNT:0] end_sum;
  logic               len_zero, ovf;
  logic               in_idle, in_load, in_issue, in_done;
  logic               take_zl, take_rej, take_acc;
  logic               last;

  assign in_idle  = (state_q == S_IDLE);
  assign in_load  = (state_q == S_LOAD);
  assign in_issue = (state_q == S_ISSUE);
  assign in_done  = (state_q == S_DONE);

  // Decode the start command: the final count value is computed one bit wider
  // so a burst running past the top of the counter range shows up as a carry.
  always_comb begin
    end_sum  = {1'b0, start_offset} + {1'b0, start_len} - {{SIZECOUNT{1'b0}}, 1'b1};
    len_zero = (start_len == '0);
    ovf      = !len_zero && end_sum[SIZECOUNT];
    take_zl  = in_idle && start && len_zero;
    take_rej = in_idle && start && ovf;
    take_acc = in_idle && start && !len_zero && !ovf;
  end

  // Next-state logic; abort overrides every transition out of LOAD/ISSUE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (take_zl)       state_d = S_DONE;
        else if (take_acc) state_d = S_LOAD;
      end
      S_LOAD:  state_d = S_ISSUE;
      S_ISSUE: if (mem.mem_ack && last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort && (in_load || in_issue)) state_d = S_IDLE;
  end

  // State, context and one-cycle event flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ctx_q   <= '0;
      err_q   <= 1'b0;
      abrt_q  <= 1'b0;
      zl_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= take_rej;
      abrt_q  <= abort && (in_load || in_issue);
      zl_q    <= take_zl;
      if (take_acc) begin
        ctx_q.base <= base_addr;
        ctx_q.max  <= end_sum[SIZECOUNT-1:0];
        ctx_q.ldv  <= start_offset;
      end
    end
  end

  // Request port and counter strobes, all decoded from the registered state so
  // an asynchronous reset drops them immediately. The final-beat flag is gated
  // by ISSUE because the counter and cnt_max both sit at 0 out of reset.
  always_comb begin
    last           = in_issue && (cnt_count == ctx_q.max);
    mem.mem_req    = in_issue;
    mem.mem_last   = last;
    mem.mem_addr   = ctx_q.base + ADDR_W'(cnt_count);
    // A beat acked together with abort still transfers but does not step.
    cnt_go         = in_issue && mem.mem_ack && !last && !abort;
    cnt_load       = in_load;
    // A zero-length burst never touched the counter, so its DONE skips the clear.
    cnt_clear      = (in_done && !zl_q) || abrt_q;
    cnt_load_value = ctx_q.ldv;
    cnt_max        = ctx_q.max;
    busy           = in_load || in_issue;
    done           = in_done;
    err            = err_q;
  end

endmodule

// File: tb/tb_burst_addr_seq.sv
// Directed bench for burst_addr_seq with a behavioural saturating counter.
module tb_burst_addr_seq;
  localparam int SC = 12;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [SC-1:0] start_offset = '0;
  logic [SC-1:0] start_len = '0;
  logic [AW-1:0] base_addr = '0;
  logic          busy, done, err, cnt_clear, cnt_load, cnt_go;
  logic [SC-1:0] cnt_load_value, cnt_max, cnt_count;

  int pass_cnt = 0;
  int total_cnt = 0;

  burst_addr_seq_if #(.ADDR_W(AW)) bus ();

  burst_addr_seq #(.SIZECOUNT(SC), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .start_offset(start_offset),
    .start_len(start_len), .base_addr(base_addr), .abort(abort),
    .busy(busy), .done(done), .err(err), .mem(bus.master),
    .cnt_clear(cnt_clear), .cnt_load(cnt_load), .cnt_load_value(cnt_load_value),
    .cnt_max(cnt_max), .cnt_go(cnt_go), .cnt_count(cnt_count)
  );

  always #5 clk = ~clk;

  // Counter: clear > load > hold-at-max > go, one edge of latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    cnt_count <= '0;
    else if (cnt_clear)           cnt_count <= '0;
    else if (cnt_load)            cnt_count <= cnt_load_value;
    else if (cnt_count == cnt_max) cnt_count <= cnt_count;
    else if (cnt_go)              cnt_count <= cnt_count + 1'b1;
  end

  // {busy, done, err, mem_req, mem_last, cnt_clear, cnt_load, cnt_go}
  wire [7:0] ov = {busy, done, err, bus.mem_req, bus.mem_last, cnt_clear, cnt_load, cnt_go};

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total_cnt++; if (ov !== 8'h00) $display("FAIL reset_ctrl got %h exp 00", ov); else pass_cnt++;
    total_cnt++; if ({cnt_max, cnt_load_value} !== 24'h0) $display("FAIL reset_cnt got %h exp 000000", {cnt_max, cnt_load_value}); else pass_cnt++;
    total_cnt++; if (bus.mem_addr !== 16'h0) $display("FAIL reset_addr got %h exp 0000", bus.mem_addr); else pass_cnt++;
    nxt(); reset = 1'b0;
    nxt();
  endtask

  task automatic test_basic();
    logic [7:0] ev [6];
    ev = '{8'h82, 8'h91, 8'h91, 8'h98, 8'h44, 8'h00};
    base_addr = 16'h1000; start_offset = 12'd4; start_len = 12'd3; start = 1'b1; bus.mem_ack = 1'b1;
    @(negedge clk);
    total_cnt++; if (ov !== 8'h00) $display("FAIL basic_c0 got %h exp 00", ov); else pass_cnt++;
    nxt(); start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      total_cnt++; if (ov !== ev[c-1]) $display("FAIL basic_ctrl_c%0d got %h exp %h", c, ov, ev[c-1]); else pass_cnt++;
      if (c >= 2 && c <= 4) begin
        total_cnt++;
        if (bus.mem_addr !== 16'h1004 + 16'(c-2)) $display("FAIL basic_addr_c%0d got %h exp %h", c, bus.mem_addr, 16'h1004 + 16'(c-2));
        else pass_cnt++;
      end
      if (c == 1) begin
        total_cnt++; if ({cnt_max, cnt_load_value} !== {12'h006, 12'h004}) $display("FAIL basic_latch got %h exp 006004", {cnt_max, cnt_load_value}); else pass_cnt++;
      end
      nxt();
    end
  endtask

  task automatic test_backpressure();
    int xfers = 0;
    int dones = 0;
    logic [7:0] e;
    logic [15:0] ea;
    base_addr = 16'h2000; start_offset = 12'h010; start_len = 12'd2; start = 1'b1; bus.mem_ack = 1'b0;
    nxt(); start = 1'b0;
    @(negedge clk);
    total_cnt++; if (ov !== 8'h82) $display("FAIL bp_load got %h exp 82", ov); else pass_cnt++;
    for (int c = 2; c <= 9; c++) begin
      nxt();
      bus.mem_ack = (c == 5 || c == 9);
      @(negedge clk);
      e  = 8'h90 | ((c >= 6) ? 8'h08 : 8'h00) | ((c == 5) ? 8'h01 : 8'h00);
      ea = (c <= 5) ? 16'h2010 : 16'h2011;
      total_cnt++; if (ov !== e) $display("FAIL bp_ctrl_c%0d got %h exp %h", c, ov, e); else pass_cnt++;
      total_cnt++; if (bus.mem_addr !== ea) $display("FAIL bp_addr_c%0d got %h exp %h", c, bus.mem_addr, ea); else pass_cnt++;
      if (bus.mem_req && bus.mem_ack) xfers++;
      if (done) dones++;
    end
    nxt(); bus.mem_ack = 1'b0;
    @(negedge clk);
    if (done) dones++;
    total_cnt++; if (ov !== 8'h44) $display("FAIL bp_done got %h exp 44", ov); else pass_cnt++;
    nxt();
    @(negedge clk);
    if (done) dones++;
    total_cnt++; if (xfers !== 2) $display("FAIL bp_xfers got %0d exp 2", xfers); else pass_cnt++;
    total_cnt++; if (dones !== 1) $display("FAIL bp_dones got %0d exp 1", dones); else pass_cnt++;
    nxt();
  endtask

  task automatic test_zero_len();
    base_addr = 16'h3000; start_offset = 12'd7; start_len = 12'd0; start = 1'b1;
    nxt(); start = 1'b0;
    @(negedge clk);
    total_cnt++; if (ov !== 8'h40) $display("FAIL zl_done got %h exp 40", ov); else pass_cnt++;
    nxt();
    @(negedge clk);
    total_cnt++; if (ov !== 8'h00) $display("FAIL zl_idle got %h exp 00", ov); else pass_cnt++;
    total_cnt++; if (cnt_max !== 12'h011) $display("FAIL zl_max got %h exp 011", cnt_max); else pass_cnt++;
    nxt();
  endtask

  task automatic test_overflow();
    base_addr = 16'h4000; start_offset = 12'hFFE; start_len = 12'd3; start = 1'b1;
    nxt(); start = 1'b0;
    @(negedge clk);
    total_cnt++; if (ov !== 8'h20) $display("FAIL ovf_err got %h exp 20", ov); else pass_cnt++;
    nxt();
    @(negedge clk);
    total_cnt++; if (ov !== 8'h00) $display("FAIL ovf_idle got %h exp 00", ov); else pass_cnt++;
    total_cnt++; if ({cnt_max, cnt_load_value} !== {12'h011, 12'h010}) $display("FAIL ovf_nolatch got %h exp 011010", {cnt_max, cnt_load_value}); else pass_cnt++;
    nxt();
    // Largest legal burst at the top of the range; the base also wraps the address.
    base_addr = 16'hF800; start_offset = 12'hFFE; start_len = 12'd2; start = 1'b1; bus.mem_ack = 1'b1;
    nxt(); start = 1'b0;
    @(negedge clk);
    total_cnt++; if ({ov, cnt_max} !== {8'h82, 12'hFFF}) $display("FAIL edge_load got %h exp 82fff", {ov, cnt_max}); else pass_cnt++;
    nxt();
    @(negedge clk);
    total_cnt++; if ({ov, bus.mem_addr} !== {8'h91, 16'h07FE}) $display("FAIL edge_beat0 got %h exp 9107fe", {ov, bus.mem_addr}); else pass_cnt++;
    nxt();
    @(negedge clk);
    total_cnt++; if ({ov, bus.mem_addr} !== {8'h98, 16'h07FF}) $display("FAIL edge_beat1 got %h exp 9807ff", {ov, bus.mem_addr}); else pass_cnt++;
    nxt();
    @(negedge clk);
    total_cnt++; if (ov !== 8'h44) $display("FAIL edge_done got %h exp 44", ov); else pass_cnt++;
    nxt();
  endtask

  task automatic test_abort();
    base_addr = 16'h5000; start_offset = 12'h020; start_len = 12'd5; start = 1'b1; bus.mem_ack = 1'b1;
    nxt(); start = 1'b0;
    nxt();
    @(negedge clk);
    total_cnt++; if ({ov, bus.mem_addr} !== {8'h91, 16'h5020}) $display("FAIL ab_beat0 got %h exp 915020", {ov, bus.mem_addr}); else pass_cnt++;
    nxt(); abort = 1'b1;
    @(negedge clk);
    total_cnt++; if ({ov, bus.mem_addr} !== {8'h90, 16'h5021}) $display("FAIL ab_beat1 got %h exp 905021", {ov, bus.mem_addr}); else pass_cnt++;
    nxt(); abort = 1'b0;
    @(negedge clk);
    total_cnt++; if (ov !== 8'h04) $display("FAIL ab_clear got %h exp 04", ov); else pass_cnt++;
    nxt();
    @(negedge clk);
    total_cnt++; if ({ov, cnt_count} !== {8'h00, 12'h000}) $display("FAIL ab_idle got %h exp 00000", {ov, cnt_count}); else pass_cnt++;
    nxt();
    base_addr = 16'h6000; start_offset = 12'h030; start_len = 12'd1; start = 1'b1;
    nxt(); start = 1'b0;
    @(negedge clk);
    total_cnt++; if (ov !== 8'h82) $display("FAIL ab_re_load got %h exp 82", ov); else pass_cnt++;
    nxt();
    @(negedge clk);
    total_cnt++; if ({ov, bus.mem_addr} !== {8'h98, 16'h6030}) $display("FAIL ab_re_beat got %h exp 986030", {ov, bus.mem_addr}); else pass_cnt++;
    nxt();
    @(negedge clk);
    total_cnt++; if (ov !== 8'h44) $display("FAIL ab_re_done got %h exp 44", ov); else pass_cnt++;
    nxt();
  endtask

  task automatic test_back_to_back();
    logic [7:0] ev [13];
    ev = '{8'h82, 8'h91, 8'h91, 8'h91, 8'h98, 8'h44, 8'h00, 8'h82, 8'h91, 8'h91, 8'h91, 8'h98, 8'h44};
    base_addr = 16'h7000; start_offset = 12'd0; start_len = 12'd4; start = 1'b1; bus.mem_ack = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      nxt();
      if (c == 3) base_addr = 16'h7100;
      if (c == 9) start = 1'b0;
      @(negedge clk);
      total_cnt++; if (ov !== ev[c-1]) $display("FAIL b2b_ctrl_c%0d got %h exp %h", c, ov, ev[c-1]); else pass_cnt++;
      if (c == 3) begin
        total_cnt++; if (bus.mem_addr !== 16'h7001) $display("FAIL b2b_hold_base got %h exp 7001", bus.mem_addr); else pass_cnt++;
      end
      if (c == 9) begin
        total_cnt++; if (bus.mem_addr !== 16'h7100) $display("FAIL b2b_new_base got %h exp 7100", bus.mem_addr); else pass_cnt++;
      end
    end
    nxt();
  endtask

  task automatic test_async_reset();
    base_addr = 16'h8000; start_offset = 12'd0; start_len = 12'd6; start = 1'b1; bus.mem_ack = 1'b1;
    nxt(); start = 1'b0;
    nxt(); nxt(); nxt();
    #2;
    total_cnt++; if ({ov, bus.mem_addr} !== {8'h91, 16'h8002}) $display("FAIL rst_beat2 got %h exp 918002", {ov, bus.mem_addr}); else pass_cnt++;
    reset = 1'b1;
    #1;
    total_cnt++; if ({ov, bus.mem_addr} !== {8'h00, 16'h0000}) $display("FAIL rst_async got %h exp 000000", {ov, bus.mem_addr}); else pass_cnt++;
    total_cnt++; if ({cnt_max, cnt_load_value} !== 24'h0) $display("FAIL rst_async_cnt got %h exp 000000", {cnt_max, cnt_load_value}); else pass_cnt++;
    nxt();
    @(negedge clk);
    total_cnt++; if (ov !== 8'h00) $display("FAIL rst_hold got %h exp 00", ov); else pass_cnt++;
    nxt(); reset = 1'b0;
    nxt();
    base_addr = 16'h9000; start_offset = 12'd5; start_len = 12'd2; start = 1'b1;
    nxt(); start = 1'b0;
    @(negedge clk);
    total_cnt++; if (ov !== 8'h82) $display("FAIL rst_re_load got %h exp 82", ov); else pass_cnt++;
    nxt();
    @(negedge clk);
    total_cnt++; if ({ov, bus.mem_addr} !== {8'h91, 16'h9005}) $display("FAIL rst_re_beat0 got %h exp 919005", {ov, bus.mem_addr}); else pass_cnt++;
    nxt();
    @(negedge clk);
    total_cnt++; if ({ov, bus.mem_addr} !== {8'h98, 16'h9006}) $display("FAIL rst_re_beat1 got %h exp 989006", {ov, bus.mem_addr}); else pass_cnt++;
    nxt();
    @(negedge clk);
    total_cnt++; if (ov !== 8'h44) $display("FAIL rst_re_done got %h exp 44", ov); else pass_cnt++;
    nxt();
  endtask

  initial begin
    bus.mem_ack = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_len();
    test_overflow();
    test_abort();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
